// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 instruction memory.
package z16_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] Z16_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD_LO,
    ST_LOAD_HI
  } z16_state_e;

endpackage

// File: rtl/z16_sram_1r1w.sv
// DEPTH x 16 array, registered read (1 cycle), single write port; no backpressure.
// Read data register holds its value until the next enabled read.
module z16_sram_1r1w
  import z16_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_dat,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_dat
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/z16_fetch_memory.sv
// Loadable Z16 instruction memory: 1-cycle fetch response, byte-serial program load.
// Fetch/load ready only in RUN/LOAD states; the response side cannot be stalled.
module z16_fetch_memory
  import z16_pkg::*;
#(
  parameter int                DEPTH     = 256,
  parameter logic [WORD_W-1:0] INIT_WORD = Z16_NOP
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_valid,
  input  logic [15:0]       i_fetch_addr,
  output logic              o_fetch_ready,
  output logic              o_instr_valid,
  output logic [WORD_W-1:0] o_instr,
  output logic              o_fault,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic              o_load_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  z16_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q;
  logic [7:0]        lo_q;
  logic              vld_q, fault_q, ovf_q, done_q;
  logic              fetch_acc, fetch_flt, ptr_full;
  logic              wr_req, ptr_inc, ptr_clr, load_end;
  logic [WORD_W-1:0] wr_dat, rd_dat;

  assign fetch_acc = i_fetch_valid && (state_q == ST_RUN);
  assign fetch_flt = i_fetch_addr[0] || (32'(i_fetch_addr[15:1]) >= 32'(DEPTH));
  // ptr saturates at DEPTH, so its top bit alone marks an out-of-range write
  assign ptr_full  = ptr_q[AW];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_req   = 1'b0;
    wr_dat   = INIT_WORD;
    ptr_inc  = 1'b0;
    ptr_clr  = 1'b0;
    load_end = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_req  = 1'b1;
        ptr_inc = 1'b1;
        if (ptr_q == PW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_load_start) begin
          ptr_clr = 1'b1;
          state_d = ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: begin
        if (i_load_valid) begin
          if (i_load_last) begin
            wr_req   = 1'b1;
            wr_dat   = {8'h00, i_load_byte};
            load_end = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d = ST_LOAD_HI;
          end
        end
      end
      ST_LOAD_HI: begin
        if (i_load_valid) begin
          wr_req   = 1'b1;
          wr_dat   = {i_load_byte, lo_q};
          ptr_inc  = 1'b1;
          load_end = i_load_last;
          state_d  = i_load_last ? ST_RUN : ST_LOAD_LO;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      lo_q    <= '0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (ptr_clr)                   ptr_q <= '0;
      else if (ptr_inc && !ptr_full) ptr_q <= ptr_q + PW'(1);
      if (state_q == ST_LOAD_LO && i_load_valid) lo_q <= i_load_byte;
      if (ptr_clr)                  ovf_q <= 1'b0;
      else if (wr_req && ptr_full)  ovf_q <= 1'b1;
      done_q <= load_end;
      vld_q  <= fetch_acc;
      if (fetch_acc) fault_q <= fetch_flt;
    end
  end

  z16_sram_1r1w #(.DEPTH(DEPTH)) u_sram (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd_en   (fetch_acc && !fetch_flt),
    .rd_addr (i_fetch_addr[AW:1]),
    .rd_dat  (rd_dat),
    .wr_en   (wr_req && !ptr_full),
    .wr_addr (ptr_q[AW-1:0]),
    .wr_dat  (wr_dat)
  );

  // fault_q and rd_dat only change on accepted fetches, so o_instr holds between responses
  assign o_instr         = fault_q ? INIT_WORD : rd_dat;
  assign o_instr_valid   = vld_q;
  assign o_fault         = vld_q && fault_q;
  assign o_fetch_ready   = (state_q == ST_RUN);
  assign o_load_ready    = (state_q == ST_LOAD_LO) || (state_q == ST_LOAD_HI);
  assign o_load_done     = done_q;
  assign o_load_overflow = ovf_q;

endmodule

// File: tb/tb_z16_fetch_memory.sv
// Randomised bench for z16_fetch_memory: a DEPTH=256 and a DEPTH=4 instance against a word-array model.
module tb_z16_fetch_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst           [2];
  logic        fetch_valid   [2];
  logic [15:0] fetch_addr    [2];
  logic        fetch_ready   [2];
  logic        instr_valid   [2];
  logic [15:0] instr         [2];
  logic        fault         [2];
  logic        load_start    [2];
  logic        load_valid    [2];
  logic [7:0]  load_byte     [2];
  logic        load_last     [2];
  logic        load_ready    [2];
  logic        load_done     [2];
  logic        load_overflow [2];

  z16_fetch_memory #(.DEPTH(256), .INIT_WORD(16'h0000)) u_big (
    .i_clk(clk), .i_rst(rst[0]),
    .i_fetch_valid(fetch_valid[0]), .i_fetch_addr(fetch_addr[0]), .o_fetch_ready(fetch_ready[0]),
    .o_instr_valid(instr_valid[0]), .o_instr(instr[0]), .o_fault(fault[0]),
    .i_load_start(load_start[0]), .i_load_valid(load_valid[0]), .i_load_byte(load_byte[0]),
    .i_load_last(load_last[0]), .o_load_ready(load_ready[0]), .o_load_done(load_done[0]),
    .o_load_overflow(load_overflow[0])
  );

  z16_fetch_memory #(.DEPTH(4), .INIT_WORD(16'h0000)) u_small (
    .i_clk(clk), .i_rst(rst[1]),
    .i_fetch_valid(fetch_valid[1]), .i_fetch_addr(fetch_addr[1]), .o_fetch_ready(fetch_ready[1]),
    .o_instr_valid(instr_valid[1]), .o_instr(instr[1]), .o_fault(fault[1]),
    .i_load_start(load_start[1]), .i_load_valid(load_valid[1]), .i_load_byte(load_byte[1]),
    .i_load_last(load_last[1]), .o_load_ready(load_ready[1]), .o_load_done(load_done[1]),
    .o_load_overflow(load_overflow[1])
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          depth_of [2];
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_instr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    fetch_valid[d] = 1'b0;
    fetch_addr[d]  = 16'h0;
    load_start[d]  = 1'b0;
    load_valid[d]  = 1'b0;
    load_byte[d]   = 8'h0;
    load_last[d]   = 1'b0;
  endtask

  function automatic bit exp_fault(input int d, input logic [15:0] a);
    return a[0] || (int'(a[15:1]) >= depth_of[d]);
  endfunction

  function automatic logic [15:0] exp_instr(input int d, input logic [15:0] a);
    if (exp_fault(d, a)) return 16'h0000;
    return ref_mem[d][int'(a[15:1])];
  endfunction

  function automatic logic [15:0] rnd_addr(input int d);
    case ($urandom_range(0, 3))
      0, 1:    return 16'(2 * $urandom_range(0, depth_of[d] - 1));
      2:       return 16'($urandom);
      default: return 16'(2 * (depth_of[d] + int'($urandom_range(0, 3))));
    endcase
  endfunction

  // Reset (optionally with a fetch and a load byte in flight), then time the clear sweep.
  task automatic do_reset(input int d, input bit pend);
    int n_low;
    rst[d] = 1'b1;
    if (pend) begin
      fetch_valid[d] = 1'b1;
      fetch_addr[d]  = 16'h0000;
      load_valid[d]  = 1'b1;
      load_byte[d]   = 8'hBB;
    end
    step();
    chk("rst_ivld",  32'(instr_valid[d]), 32'd0);
    chk("rst_instr", 32'(instr[d]), 32'd0);
    chk("rst_fault", 32'(fault[d]), 32'd0);
    chk("rst_frdy",  32'(fetch_ready[d]), 32'd0);
    chk("rst_lrdy",  32'(load_ready[d]), 32'd0);
    chk("rst_done",  32'(load_done[d]), 32'd0);
    chk("rst_ovf",   32'(load_overflow[d]), 32'd0);
    idle(d);
    rst[d] = 1'b0;
    n_low = 1;
    for (int k = 0; k < 2 * depth_of[d] + 8 && !fetch_ready[d]; k++) begin
      step();
      if (!fetch_ready[d]) n_low++;
    end
    chk("clear_len", 32'(n_low), 32'(depth_of[d]));
    chk("run_frdy",  32'(fetch_ready[d]), 32'd1);
    for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0000;
    last_instr[d] = 16'h0000;
  endtask

  task automatic fetch_seq(input int d, input logic [15:0] aq[$]);
    foreach (aq[i]) begin
      fetch_valid[d] = 1'b1;
      fetch_addr[d]  = aq[i];
      step();
      chk("f_vld",   32'(instr_valid[d]), 32'd1);
      chk("f_fault", 32'(fault[d]), 32'(exp_fault(d, aq[i])));
      chk("f_instr", 32'(instr[d]), 32'(exp_instr(d, aq[i])));
      last_instr[d] = exp_instr(d, aq[i]);
    end
    fetch_valid[d] = 1'b0;
    step();
    chk("f_idle_vld",  32'(instr_valid[d]), 32'd0);
    chk("f_idle_hold", 32'(instr[d]), 32'(last_instr[d]));
  endtask

  task automatic do_load(input int d, input logic [7:0] bq[$], input bit with_fetch);
    bit          early;
    int          nw;
    logic [15:0] fa;
    load_start[d] = 1'b1;
    fa = rnd_addr(d);
    if (with_fetch) begin
      fetch_valid[d] = 1'b1;
      fetch_addr[d]  = fa;
    end
    step();
    load_start[d]  = 1'b0;
    fetch_valid[d] = 1'b0;
    if (with_fetch) begin
      chk("ls_f_vld",   32'(instr_valid[d]), 32'd1);
      chk("ls_f_instr", 32'(instr[d]), 32'(exp_instr(d, fa)));
      last_instr[d] = exp_instr(d, fa);
    end
    chk("ld_rdy",  32'(load_ready[d]), 32'd1);
    chk("ld_frdy", 32'(fetch_ready[d]), 32'd0);
    chk("ovf_clr", 32'(load_overflow[d]), 32'd0);
    early = 1'b0;
    foreach (bq[i]) begin
      repeat ($urandom_range(0, 1)) begin
        load_valid[d]  = 1'b0;
        load_start[d]  = 1'b1;
        fetch_valid[d] = 1'b1;
        step();
        if (load_done[d] || instr_valid[d] || !load_ready[d]) early = 1'b1;
      end
      load_start[d]  = 1'b0;
      fetch_valid[d] = 1'b0;
      load_valid[d]  = 1'b1;
      load_byte[d]   = bq[i];
      load_last[d]   = (i == bq.size() - 1);
      step();
      if (i != bq.size() - 1 && (load_done[d] || instr_valid[d] || !load_ready[d])) early = 1'b1;
    end
    idle(d);
    nw = (bq.size() + 1) / 2;
    for (int k = 0; k < nw && k < depth_of[d]; k++)
      ref_mem[d][k] = {((2 * k + 1 < bq.size()) ? bq[2 * k + 1] : 8'h00), bq[2 * k]};
    chk("ld_early", 32'(early), 32'd0);
    chk("ld_done",  32'(load_done[d]), 32'd1);
    chk("ld_frdy2", 32'(fetch_ready[d]), 32'd1);
    chk("ld_ovf",   32'(load_overflow[d]), 32'(nw > depth_of[d]));
    step();
    chk("ld_pulse", 32'(load_done[d]), 32'd0);
    chk("ld_ovf_sticky", 32'(load_overflow[d]), 32'(nw > depth_of[d]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  bq[$];
    logic [15:0] aq[$];
    int          d;
    depth_of[0] = 256;
    depth_of[1] = 4;
    for (int i = 0; i < 2; i++) begin
      idle(i);
      rst[i] = 1'b1;
    end

    do_reset(0, 1'b0);
    do_reset(1, 1'b0);

    aq = '{16'h0010};
    fetch_seq(0, aq);
    bq = '{8'h40, 8'h00, 8'h5D, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6C, 8'h00};
    do_load(0, bq, 1'b0);
    aq = '{16'h0000, 16'h0002, 16'h0008};
    fetch_seq(0, aq);
    aq = '{16'h0003, 16'h0200, 16'h01FE, 16'hFFFF};
    fetch_seq(0, aq);
    bq = '{8'h34, 8'h12, 8'h78};
    do_load(0, bq, 1'b1);
    aq = '{16'h0000, 16'h0002, 16'h0004};
    fetch_seq(0, aq);

    bq = '{};
    for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
    do_load(1, bq, 1'b0);
    aq = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    fetch_seq(1, aq);
    bq = '{8'hA1, 8'hB2, 8'hC3};
    do_load(1, bq, 1'b1);
    aq = '{16'h0006, 16'h0000, 16'h0002};
    fetch_seq(1, aq);

    repeat (24) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        bq = '{};
        repeat ($urandom_range(1, (d == 0) ? 24 : 12)) bq.push_back(8'($urandom));
        do_load(d, bq, 1'($urandom_range(0, 1)));
      end else begin
        aq = '{};
        repeat ($urandom_range(1, 6)) aq.push_back(rnd_addr(d));
        fetch_seq(d, aq);
      end
    end

    bq = '{8'hAA, 8'h55};
    do_load(0, bq, 1'b0);
    aq = '{16'h0000};
    fetch_seq(0, aq);
    load_start[0] = 1'b1;
    step();
    load_start[0] = 1'b0;
    load_valid[0] = 1'b1;
    load_byte[0]  = 8'h11;
    load_last[0]  = 1'b0;
    step();
    chk("mid_lrdy", 32'(load_ready[0]), 32'd1);
    do_reset(0, 1'b1);
    aq = '{16'h0000, 16'h0002};
    fetch_seq(0, aq);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
